// File: rtl/ccff_pkg.sv
// Shared types and CRC-8 helper for the configuration-chain loader.
// CRC checking is compiled in only when CCFF_LOADER_CRC_CHECK_EN is defined.
package ccff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_CRC_FETCH,
        ST_DONE
    } ccff_ld_state_e;

    localparam logic [7:0] CCFF_CRC_POLY = 8'h07;

    // MSB-first CRC-8, one serial bit per call.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       din
    );
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Bit-serial CRC-8 engine with synchronous clear and enable.
// Instantiated by ccff_loader only under CCFF_LOADER_CRC_CHECK_EN.
module ccff_crc8
    import ccff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Serialises bitstream words into a fabric configuration chain, MSB first.
// Define CCFF_LOADER_CRC_CHECK_EN to add a trailing CRC-8 word check.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 4096,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CHAIN_N  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  WORD_N   = WB_W'(WORD_W);

    ccff_ld_state_e    state_q;
    logic [WORD_W-1:0] sreg_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [WB_W-1:0]   word_bits_q;
    logic              head_q;
    logic              shift_en_q;

    logic              word_end;
    logic              chain_end;
    logic              start_ok;
    logic              hs;
    logic [CNT_W-1:0]  remain;
    logic [WB_W-1:0]   load_bits;

    assign word_end  = (word_bits_q == WB_W'(1));
    assign chain_end = (bit_cnt_q == LAST_BIT);
    assign start_ok  = start &&
                       (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        cfg_ready = 1'b0;
        unique case (state_q)
            ST_FETCH:     cfg_ready = 1'b1;
            ST_SHIFT:     cfg_ready = word_end && !chain_end;
`ifdef CCFF_LOADER_CRC_CHECK_EN
            ST_CRC_FETCH: cfg_ready = 1'b1;
`endif
            default:      cfg_ready = 1'b0;
        endcase
    end

    assign hs = cfg_valid && cfg_ready;

    // A reload in SHIFT takes effect after the bit now on the wire.
    assign remain = (state_q == ST_SHIFT)
                  ? CHAIN_N - bit_cnt_q - CNT_W'(1)
                  : CHAIN_N - bit_cnt_q;

    assign load_bits = (32'(remain) < WORD_W)
                     ? WB_W'(remain)
                     : WORD_N;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
        end else begin
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q   <= ST_FETCH;
                        bit_cnt_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (hs) begin
                        sreg_q      <= cfg_data << 1;
                        head_q      <= cfg_data[WORD_W-1];
                        word_bits_q <= load_bits;
                        shift_en_q  <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
                    word_bits_q <= word_bits_q - WB_W'(1);
                    if (chain_end) begin
`ifdef CCFF_LOADER_CRC_CHECK_EN
                        state_q <= ST_CRC_FETCH;
`else
                        state_q <= ST_DONE;
`endif
                    end else if (!word_end) begin
                        head_q     <= sreg_q[WORD_W-1];
                        sreg_q     <= sreg_q << 1;
                        shift_en_q <= 1'b1;
                    end else if (hs) begin
                        sreg_q      <= cfg_data << 1;
                        head_q      <= cfg_data[WORD_W-1];
                        word_bits_q <= load_bits;
                        shift_en_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
`ifdef CCFF_LOADER_CRC_CHECK_EN
                ST_CRC_FETCH: begin
                    if (hs) begin
                        state_q <= ST_DONE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q == ST_FETCH) ||
                           (state_q == ST_SHIFT) ||
                           (state_q == ST_CRC_FETCH);
    assign done          = (state_q == ST_DONE);

`ifdef CCFF_LOADER_CRC_CHECK_EN
    logic [7:0] crc_val;
    logic       crc_err_q;

    ccff_crc8 u_crc (
        .clk (prog_clk),
        .rst (prog_reset),
        .clr (start_ok),
        .en  (shift_en_q),
        .din (head_q),
        .crc (crc_val)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset || start_ok) begin
            crc_err_q <= 1'b0;
        end else if (state_q == ST_CRC_FETCH && hs) begin
            crc_err_q <= (cfg_data[7:0] != crc_val);
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule
